// File: rtl/fifo_reader_if.sv
// Handshake bundle for fifo_reader: FIFO read side plus the output stream.
// master = the reader itself, slave = the FIFO/stream environment around it.
interface fifo_reader_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  enable;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data_out;
   logic                  fifo_r_en;
   logic                  m_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_ready;
   logic                  busy;
   logic [15:0]           word_count;

   modport master (
      input  enable, fifo_empty, fifo_data_out, m_ready,
      output fifo_r_en, m_valid, m_data, busy, word_count
   );

   modport slave (
      output enable, fifo_empty, fifo_data_out, m_ready,
      input  fifo_r_en, m_valid, m_data, busy, word_count
   );
endinterface

// File: rtl/fifo_reader.sv
// Drains a 1-cycle-latency FIFO into a valid/ready stream through a
// 2-entry skid buffer, keeping at most one read in flight.
module fifo_reader #(
   parameter int DATA_WIDTH = 16
) (
   input  logic           clk,
   input  logic           rst,
   fifo_reader_if.master  bus
);

   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

   state_t                state, state_next;
   logic [1:0]            occ;
   logic                  infl;
   logic [DATA_WIDTH-1:0] slot0, slot1;
   logic [15:0]           wc;
   logic                  pop, cap, rd_en;
   logic [2:0]            level;

   // A transfer pops the head; a capture lands the word read last cycle.
   assign pop   = (occ != 2'd0) && bus.m_ready;
   assign cap   = infl;
   // Buffer fill once this cycle's capture and transfer are applied.
   assign level = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state and read-strobe decode; no read may issue while in reset.
   always_comb begin
      state_next = state;
      rd_en      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.enable) state_next = ACTIVE;
         end
         ACTIVE: begin
            if (!bus.enable) state_next = FLUSH;
            rd_en = bus.enable && !bus.fifo_empty && (level < 3'd2);
         end
         FLUSH: begin
            if (bus.enable)         state_next = ACTIVE;
            else if (level == 3'd0) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (rst) rd_en = 1'b0;
   end

   // Buffer, in-flight flag and transfer counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ   <= '0;
         infl  <= 1'b0;
         slot0 <= '0;
         slot1 <= '0;
         wc    <= '0;
      end else begin
         infl <= rd_en;
         occ  <= level[1:0];
         wc   <= wc + {15'd0, pop};
         case ({cap, pop})
            2'b01: slot0 <= slot1;
            2'b10: begin
               if (occ == 2'd0) slot0 <= bus.fifo_data_out;
               else             slot1 <= bus.fifo_data_out;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  slot0 <= bus.fifo_data_out;
               end else begin
                  slot0 <= slot1;
                  slot1 <= bus.fifo_data_out;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.fifo_r_en  = rd_en;
   assign bus.m_valid    = (occ != 2'd0);
   assign bus.m_data     = slot0;
   assign bus.busy       = (state != IDLE);
   assign bus.word_count = wc;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: behavioural FIFO source, queue scoreboard
// on the output stream, and a linear sequence of scenarios.
module tb_fifo_reader;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_reader_if #(.DATA_WIDTH(16)) bus ();

   fifo_reader #(.DATA_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [15:0] fifo_mem [$];
   logic [15:0] exp_q    [$];
   int rd_ptr  = 0;
   int exp_ptr = 0;
   int rd_cnt  = 0;
   int rd0;
   int n;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [15:0] d);
      fifo_mem.push_back(d);
      exp_q.push_back(d);
   endtask

   task automatic step(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst        = 1'b1;
      bus.enable = 1'b0;
      bus.m_ready = 1'b0;
      step(2);
      rst = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int limit);
      int k = 0;
      while (((exp_q.size() - exp_ptr) != 0 || bus.m_valid) && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk(tag, ((exp_q.size() - exp_ptr) == 0) && !bus.m_valid, 1'b1);
   endtask

   // FIFO source with one cycle of read latency; reset discards leftovers.
   assign bus.fifo_empty = (rd_ptr >= fifo_mem.size());
   always @(posedge clk) begin
      if (rst) begin
         rd_ptr <= fifo_mem.size();
      end else if (bus.fifo_r_en) begin
         rd_cnt <= rd_cnt + 1;
         if (rd_ptr < fifo_mem.size()) begin
            bus.fifo_data_out <= fifo_mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
         end else begin
            bus.fifo_data_out <= 'x;
         end
      end
   end

   // Stream monitor: every transfer must match the next expected word.
   always @(negedge clk) begin
      if (rst) begin
         exp_ptr = exp_q.size();
      end else begin
         if (bus.fifo_r_en) chk("rd_while_empty", bus.fifo_empty, 1'b0);
         if (bus.m_valid && bus.m_ready) begin
            chk("xfer_expected", exp_ptr < exp_q.size(), 1'b1);
            if (exp_ptr < exp_q.size()) begin
               chk("m_data_order", bus.m_data, exp_q[exp_ptr]);
               exp_ptr++;
            end
         end
      end
   end

   initial begin
      rst         = 1'b1;
      bus.enable  = 1'b0;
      bus.m_ready = 1'b0;
      step(2);
      @(negedge clk);
      chk("rst_m_valid", bus.m_valid, 1'b0);
      chk("rst_m_data", bus.m_data, 16'h0000);
      chk("rst_word_count", bus.word_count, 16'h0000);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_r_en", bus.fifo_r_en, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic drain: three words back to back.
      do_reset();
      rd0 = rd_cnt;
      push(16'h0001); push(16'h0002); push(16'h0003);
      bus.enable  = 1'b1;
      bus.m_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.m_valid && n < 10) begin @(negedge clk); n++; end
      chk("drain_first_valid_cycle", n, 3);
      for (int k = 1; k <= 3; k++) begin
         chk("drain_seq_valid", bus.m_valid, 1'b1);
         chk("drain_seq_data", bus.m_data, k);
         @(negedge clk);
      end
      wait_drain("drain_done", 20);
      chk("drain_word_count", bus.word_count, 16'd3);
      chk("drain_reads", rd_cnt - rd0, 3);
      chk("drain_busy_active", bus.busy, 1'b1);

      // Backpressure: only two reads until the stream accepts.
      do_reset();
      rd0 = rd_cnt;
      for (int k = 0; k < 5; k++) push(16'h0010 + k[15:0]);
      bus.enable = 1'b1;
      step(8);
      @(negedge clk);
      chk("bp_reads", rd_cnt - rd0, 2);
      chk("bp_valid", bus.m_valid, 1'b1);
      for (int k = 0; k < 4; k++) begin
         chk("bp_data_frozen", bus.m_data, 16'h0010);
         @(negedge clk);
      end
      @(posedge clk); #1;
      bus.m_ready = 1'b1;
      wait_drain("bp_done", 30);
      chk("bp_word_count", bus.word_count, 16'd5);
      chk("bp_reads_total", rd_cnt - rd0, 5);

      // Flush: enable drops right after a read issues.
      do_reset();
      rd0 = rd_cnt;
      bus.m_ready = 1'b1;
      for (int k = 0; k < 4; k++) push(16'h0020 + k[15:0]);
      bus.enable = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.fifo_r_en && n < 10) begin @(negedge clk); n++; end
      chk("flush_read_seen", bus.fifo_r_en, 1'b1);
      @(posedge clk); #1;
      bus.enable = 1'b0;
      @(negedge clk);
      chk("flush_no_read", bus.fifo_r_en, 1'b0);
      chk("flush_busy", bus.busy, 1'b1);
      n = 0;
      while (!bus.m_valid && n < 10) begin @(negedge clk); n++; end
      chk("flush_inflight_valid", bus.m_valid, 1'b1);
      chk("flush_inflight_data", bus.m_data, 16'h0020);
      chk("flush_busy_last", bus.busy, 1'b1);
      @(negedge clk);
      chk("flush_busy_fall", bus.busy, 1'b0);
      chk("flush_valid_fall", bus.m_valid, 1'b0);
      repeat (5) @(negedge clk);
      chk("flush_reads", rd_cnt - rd0, 1);
      chk("flush_left_pending", exp_q.size() - exp_ptr, 3);

      // Empty boundary: single word, then wait in ACTIVE.
      do_reset();
      rd0 = rd_cnt;
      bus.m_ready = 1'b1;
      push(16'h0030);
      bus.enable = 1'b1;
      repeat (8) @(negedge clk);
      chk("empty_pending", exp_q.size() - exp_ptr, 0);
      chk("empty_reads", rd_cnt - rd0, 1);
      chk("empty_r_en_low", bus.fifo_r_en, 1'b0);
      chk("empty_busy", bus.busy, 1'b1);
      chk("empty_word_count", bus.word_count, 16'd1);
      @(posedge clk); #1;
      push(16'h0031);
      wait_drain("empty_resume", 10);
      chk("empty_word_count2", bus.word_count, 16'd2);

      // Reset mid-stream with a read in flight.
      do_reset();
      bus.m_ready = 1'b1;
      for (int k = 0; k < 8; k++) push(16'h0040 + k[15:0]);
      bus.enable = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.m_valid && n < 10) begin @(negedge clk); n++; end
      chk("midrst_streaming", bus.m_valid, 1'b1);
      @(posedge clk); #1;
      rst         = 1'b1;
      bus.m_ready = 1'b0;
      bus.enable  = 1'b0;
      @(negedge clk);
      chk("midrst_no_read", bus.fifo_r_en, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_valid", bus.m_valid, 1'b0);
      chk("midrst_word_count", bus.word_count, 16'h0000);
      chk("midrst_busy", bus.busy, 1'b0);
      chk("midrst_data", bus.m_data, 16'h0000);
      @(negedge clk);
      chk("midrst_no_capture", bus.m_valid, 1'b0);

      // Counter wrap after 65535 transfers.
      do_reset();
      bus.m_ready = 1'b1;
      for (int k = 0; k < 65535; k++) push(k[15:0]);
      bus.enable = 1'b1;
      wait_drain("wrap_bulk", 70000);
      chk("wrap_full", bus.word_count, 16'hFFFF);
      @(posedge clk); #1;
      push(16'hBEEF);
      wait_drain("wrap_last", 20);
      chk("wrap_zero", bus.word_count, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 The block SHALL have exactly one parameter: DATA_WIDTH, default 16, width of the FIFO read data and the stream data.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, input, 1, rising-edge clock for all state.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, level request to drain the FIFO.
- fifo_empty, input, 1, FIFO empty flag.
- fifo_data_out, input, DATA_WIDTH, FIFO read data, valid exactly 1 cycle after fifo_r_en.
- fifo_r_en, output, 1, FIFO read strobe, one word per asserted cycle.
- m_valid, output, 1, stream data valid.
- m_data, output, DATA_WIDTH, stream data.
- m_ready, input, 1, downstream accept.
- busy, output, 1, high in ACTIVE and FLUSH.
- word_count, output, 16, count of accepted stream transfers.

Function
REQ-004 The block SHALL hold a 2-entry output buffer (occ = 0..2) plus at most 1 in-flight read (infl = 0..1).
REQ-005 fifo_r_en SHALL be asserted iff state==ACTIVE, enable==1, fifo_empty==0 and (occ + infl - pop) < 2, where pop = m_valid && m_ready in the same cycle.
REQ-006 fifo_r_en SHALL never be asserted while fifo_empty==1.
REQ-007 The word on fifo_data_out SHALL be written into the buffer on the cycle after fifo_r_en, with no other qualification.
REQ-008 m_valid SHALL equal (occ != 0), and m_data SHALL present the oldest buffered word.
REQ-009 A transfer SHALL occur iff m_valid && m_ready; it removes the oldest entry.
REQ-010 A simultaneous capture and transfer SHALL leave occ unchanged and preserve order.
REQ-011 m_data SHALL hold stable while m_valid && !m_ready.
REQ-012 Minimum latency SHALL be 2 cycles: fifo_r_en at cycle N, capture at N+1, m_valid at N+1 after the edge. Sustained throughput SHALL be 1 word/cycle while m_ready==1 and the FIFO is non-empty.
REQ-013 word_count SHALL increment by 1 per transfer and wrap from 0xFFFF to 0x0000.
REQ-014 The state machine SHALL have three states: IDLE, ACTIVE and FLUSH.
- IDLE -> ACTIVE when enable==1.
- ACTIVE -> FLUSH when enable==0.
- FLUSH -> ACTIVE when enable==1.
- FLUSH -> IDLE when occ==0 and infl==0, after accounting for this cycle's transfer.
REQ-015 In FLUSH, no new reads SHALL issue; buffered and in-flight words SHALL still be delivered.
REQ-016 busy SHALL be 1 in ACTIVE and FLUSH, and 0 in IDLE.
REQ-017 fifo_empty rising while a read is in flight SHALL NOT cancel that capture.

Reset
REQ-018 When rst==1 at a clock edge, the block SHALL set: state=IDLE, occ=0, infl=0, fifo_r_en=0, m_valid=0, m_data=0, word_count=0, busy=0.
REQ-019 A read in flight at reset SHALL be discarded; its data SHALL NOT be captured on the following cycle.
REQ-020 Reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Basic drain: FIFO holds 0x0001,0x0002,0x0003; enable=1, m_ready=1 -> m_data 0x0001,0x0002,0x0003 on consecutive cycles; word_count=3; fifo_r_en never high with fifo_empty=1.
- Backpressure: m_ready=0 with 5 words queued -> exactly 2 reads issued, m_data frozen at the first word; m_ready=1 -> all 5 words delivered in order with no loss or duplication.
- Flush: enable drops the same cycle fifo_r_en=1 -> state FLUSH, the in-flight word is delivered, busy falls after the last transfer, no further fifo_r_en.
- Empty boundary: FIFO has 1 word, fifo_empty asserts the cycle after the read -> one word out, fifo_r_en stays 0, block remains ACTIVE and waits.
- Count wrap: word_count preloaded via 65535 transfers, one more transfer -> word_count=0x0000.
- Reset mid-operation: rst=1 with occ=2 and a read in flight -> next cycle m_valid=0, word_count=0, busy=0, and no capture of the in-flight data.
